// File: rtl/mc_main_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main control unit and the
// ALU decoder that consumes its ALUOp.
package mc_main_control_fsm_pkg;

   // Opcode field instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALUOp codes shared with the ALU decoder
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b100;

   // Main FSM state encodings; 12-15 are unused and recover to FETCH
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_IEXEC    = 4'd9,
      S_IWB      = 4'd10,
      S_JUMP     = 4'd11
   } state_e;

endpackage

// File: rtl/mc_main_control_fsm_if.sv
// Control bus between the main control FSM (master) and the datapath (slave).
interface mc_main_control_fsm_if;
   logic [5:0] op;
   logic       zero;
   logic [2:0] ALUOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       ZeroExt;
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic [1:0] PCSrc;
   logic       pc_en;
   logic       illegal_op;

   modport master (
      input  op, zero,
      output ALUOp, ALUSrcA, ALUSrcB, ZeroExt, IorD, MemWrite, IRWrite,
             RegDst, MemtoReg, RegWrite, PCSrc, pc_en, illegal_op
   );

   modport slave (
      output op, zero,
      input  ALUOp, ALUSrcA, ALUSrcB, ZeroExt, IorD, MemWrite, IRWrite,
             RegDst, MemtoReg, RegWrite, PCSrc, pc_en, illegal_op
   );
endinterface

// File: rtl/mc_main_control_fsm.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving the datapath enables and ALUOp.
module mc_main_control_fsm
   import mc_main_control_fsm_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   mc_main_control_fsm_if.master bus,
   output logic [STATE_W-1:0]    state_o
);

   state_e     state_q, state_d;

   logic [2:0] aluop_d;
   logic       srca_d;
   logic [1:0] srcb_d;
   logic       zext_d;
   logic       iord_d;
   logic       memwrite_d;
   logic       irwrite_d;
   logic       regdst_d;
   logic       memtoreg_d;
   logic       regwrite_d;
   logic [1:0] pcsrc_d;
   logic       pcwrite_d;
   logic       branch_d;
   logic       illegal_d;

   // State register; reset lands in FETCH immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state and per-state control decode
   always_comb begin
      state_d    = S_FETCH;
      aluop_d    = ALUOP_ADD;
      srca_d     = 1'b0;
      srcb_d     = 2'b00;
      zext_d     = 1'b0;
      iord_d     = 1'b0;
      memwrite_d = 1'b0;
      irwrite_d  = 1'b0;
      regdst_d   = 1'b0;
      memtoreg_d = 1'b0;
      regwrite_d = 1'b0;
      pcsrc_d    = 2'b00;
      pcwrite_d  = 1'b0;
      branch_d   = 1'b0;
      illegal_d  = 1'b0;
      case (state_q)
         S_FETCH: begin
            state_d   = S_DECODE;
            srcb_d    = 2'b01;
            irwrite_d = 1'b1;
            pcwrite_d = 1'b1;
         end
         S_DECODE: begin
            srcb_d = 2'b11;
            case (bus.op)
               OP_LW, OP_SW:           state_d = S_MEMADR;
               OP_RTYPE:               state_d = S_EXECUTE;
               OP_BEQ:                 state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
               OP_J:                   state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            srca_d = 1'b1;
            srcb_d = 2'b10;
            // op was validated in DECODE; anything else just retires
            if (bus.op == OP_LW)      state_d = S_MEMREAD;
            else if (bus.op == OP_SW) state_d = S_MEMWRITE;
            else                      state_d = S_FETCH;
         end
         S_MEMREAD: begin
            state_d = S_MEMWB;
            iord_d  = 1'b1;
         end
         S_MEMWB: begin
            memtoreg_d = 1'b1;
            regwrite_d = 1'b1;
         end
         S_MEMWRITE: begin
            iord_d     = 1'b1;
            memwrite_d = 1'b1;
         end
         S_EXECUTE: begin
            state_d = S_ALUWB;
            srca_d  = 1'b1;
            aluop_d = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regdst_d   = 1'b1;
            regwrite_d = 1'b1;
         end
         S_BRANCH: begin
            srca_d   = 1'b1;
            aluop_d  = ALUOP_SUB;
            pcsrc_d  = 2'b01;
            branch_d = 1'b1;
         end
         S_IEXEC: begin
            state_d = S_IWB;
            srca_d  = 1'b1;
            srcb_d  = 2'b10;
            if (bus.op == OP_ANDI) begin
               aluop_d = ALUOP_AND;
               zext_d  = 1'b1;
            end else if (bus.op == OP_ORI) begin
               aluop_d = ALUOP_OR;
               zext_d  = 1'b1;
            end
         end
         S_IWB: regwrite_d = 1'b1;
         S_JUMP: begin
            pcsrc_d   = 2'b10;
            pcwrite_d = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Architectural write enables are suppressed while reset is held so an
   // abandoned instruction cannot finish a write.
   assign bus.ALUOp      = aluop_d;
   assign bus.ALUSrcA    = srca_d;
   assign bus.ALUSrcB    = srcb_d;
   assign bus.ZeroExt    = zext_d;
   assign bus.IorD       = iord_d;
   assign bus.MemWrite   = memwrite_d & ~reset;
   assign bus.IRWrite    = irwrite_d & ~reset;
   assign bus.RegDst     = regdst_d;
   assign bus.MemtoReg   = memtoreg_d;
   assign bus.RegWrite   = regwrite_d & ~reset;
   assign bus.PCSrc      = pcsrc_d;
   assign bus.pc_en      = (pcwrite_d | (branch_d & bus.zero)) & ~reset;
   assign bus.illegal_op = illegal_d;

   assign state_o = STATE_W'(state_q);

endmodule
